// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON memory sequencer: FSM states,
// response status codes and the 160-bit record field layout.
package ascon_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ENC_START,
        ENC_WAIT,
        WR_REC,
        RD_REC,
        RD_WAIT,
        DEC_START,
        DEC_WAIT,
        RESPOND,
        RECOVER
    } seq_state_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_AUTH_FAIL = 2'd1,
        ST_TIMEOUT   = 2'd2
    } rsp_status_t;

    // Record layout mirrors the engine's tag compare: tag halves are swapped.
    localparam int REC_CT_MSB    = 159;
    localparam int REC_CT_LSB    = 128;
    localparam int REC_TAGLO_MSB = 127;
    localparam int REC_TAGLO_LSB = 64;
    localparam int REC_TAGHI_MSB = 63;
    localparam int REC_TAGHI_LSB = 0;

    localparam logic [63:0] ASCON_IV = 64'h8040_0c06_0000_0000;

    function automatic logic [159:0] build_record(input logic [31:0] ct, input logic [127:0] tag);
        logic [159:0] rec;
        rec = '0;
        rec[REC_CT_MSB:REC_CT_LSB]       = ct;
        rec[REC_TAGLO_MSB:REC_TAGLO_LSB] = tag[63:0];
        rec[REC_TAGHI_MSB:REC_TAGHI_LSB] = tag[127:64];
        return rec;
    endfunction

endpackage

// File: rtl/ascon_mem_sequencer_if.sv
// Core-side load/store request and response channels of the sequencer.
interface ascon_mem_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_status;

    // Handshake: a beat transfers on a cycle where valid && ready; the sender
    // holds valid and payload stable until then, and valid never waits on ready.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_status
    );
endinterface

// File: rtl/ascon_seq_watchdog.sv
// Engine-operation watchdog: cleared before each wait phase, counts while
// enabled and flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module ascon_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/ascon_mem_sequencer.sv
// Sequences 32-bit loads/stores through the ASCON engine: stores become
// authenticated 160-bit records, loads are decrypted and verified.
module ascon_mem_sequencer
    import ascon_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    ascon_mem_sequencer_if.slave bus,
    output logic                 rec_wr_en,
    output logic                 rec_rd_en,
    output logic [ADDR_W-1:0]    rec_addr,
    output logic [159:0]         rec_wr_data,
    input  logic [159:0]         rec_rd_data,
    output logic                 eng_rst,
    output logic                 eng_en,
    output logic                 eng_enc_start,
    output logic                 eng_dec_start,
    output logic [31:0]          eng_plaintext,
    output logic [159:0]         eng_ciphertext,
    input  logic [31:0]          eng_message,
    input  logic [127:0]         eng_tag,
    input  logic                 eng_store_ready,
    input  logic                 eng_auth_done,
    input  logic                 eng_dec_fail,
    output seq_state_t           dbg_state
);
    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [159:0]      rec_q;
    logic [31:0]       shadow_q;
    logic [31:0]       rdata_q;
    rsp_status_t       status_q;

    logic              wd_clear, wd_en, wd_expired;
    logic              rsp_load;
    logic [31:0]       rsp_rdata_d;
    rsp_status_t       rsp_status_d;

    ascon_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wd_clear       = 1'b0;
        wd_en          = 1'b0;
        rsp_load       = 1'b0;
        rsp_rdata_d    = '0;
        rsp_status_d   = ST_OK;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_rdata  = '0;
        bus.rsp_status = '0;
        rec_wr_en      = 1'b0;
        rec_rd_en      = 1'b0;
        rec_addr       = '0;
        rec_wr_data    = '0;
        eng_en         = 1'b0;
        eng_enc_start  = 1'b0;
        eng_dec_start  = 1'b0;
        eng_plaintext  = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = bus.req_write ? ENC_START : RD_REC;
                end
            end
            ENC_START: begin
                eng_en        = 1'b1;
                eng_enc_start = 1'b1;
                eng_plaintext = wdata_q;
                wd_clear      = 1'b1;
                state_d       = ENC_WAIT;
            end
            ENC_WAIT: begin
                eng_en        = 1'b1;
                eng_plaintext = wdata_q;
                wd_en         = 1'b1;
                // Completion is checked first so it wins a same-cycle expiry.
                if (eng_store_ready) begin
                    state_d = WR_REC;
                end else if (wd_expired) begin
                    state_d = RECOVER;
                end
            end
            WR_REC: begin
                rec_wr_en   = 1'b1;
                rec_addr    = addr_q;
                rec_wr_data = rec_q;
                rsp_load    = 1'b1;
                state_d     = RESPOND;
            end
            RD_REC: begin
                rec_rd_en = 1'b1;
                rec_addr  = addr_q;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                state_d = DEC_START;
            end
            DEC_START: begin
                eng_en        = 1'b1;
                eng_dec_start = 1'b1;
                wd_clear      = 1'b1;
                state_d       = DEC_WAIT;
            end
            DEC_WAIT: begin
                eng_en = 1'b1;
                wd_en  = 1'b1;
                if (eng_auth_done) begin
                    rsp_load     = 1'b1;
                    rsp_status_d = eng_dec_fail ? ST_AUTH_FAIL : ST_OK;
                    rsp_rdata_d  = eng_dec_fail ? 32'h0 : shadow_q;
                    state_d      = RESPOND;
                end else if (wd_expired) begin
                    state_d = RECOVER;
                end
            end
            RESPOND: begin
                bus.rsp_valid  = 1'b1;
                bus.rsp_rdata  = rdata_q;
                bus.rsp_status = status_q;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                rsp_load     = 1'b1;
                rsp_status_d = ST_TIMEOUT;
                state_d      = RESPOND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rec_q    <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
            status_q <= ST_OK;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == ENC_WAIT && eng_store_ready) begin
                rec_q <= build_record(eng_message, eng_tag);
            end
            if (state_q == RD_WAIT) begin
                rec_q <= rec_rd_data;
            end
            // The engine clears its message when auth_done rises, so the
            // shadow must hold the value from the cycle before.
            if (state_q == DEC_WAIT && !eng_auth_done) begin
                shadow_q <= eng_message;
            end
            if (rsp_load) begin
                rdata_q  <= rsp_rdata_d;
                status_q <= rsp_status_d;
            end
        end
    end

    assign eng_rst        = rst || (state_q == RECOVER);
    assign eng_ciphertext = rec_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_ascon_mem_sequencer.sv
// Scoreboard bench for ascon_mem_sequencer with a toy-cipher engine stub,
// a record memory and a plaintext-level reference model.
`timescale 1ns/1ps
module tb_ascon_mem_sequencer;
    import ascon_pkg::*;

    localparam int ADDR_W         = 10;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int DEPTH          = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_mem_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    logic              rec_wr_en, rec_rd_en;
    logic [ADDR_W-1:0] rec_addr;
    logic [159:0]      rec_wr_data;
    logic [159:0]      rec_rd_data = '0;
    logic              eng_rst, eng_en, eng_enc_start, eng_dec_start;
    logic [31:0]       eng_plaintext;
    logic [159:0]      eng_ciphertext;
    logic [31:0]       eng_message     = '0;
    logic [127:0]      eng_tag         = '0;
    logic              eng_store_ready = 1'b0;
    logic              eng_auth_done   = 1'b0;
    logic              eng_dec_fail    = 1'b0;
    seq_state_t        dbg_state;

    ascon_mem_sequencer #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .rec_wr_en(rec_wr_en), .rec_rd_en(rec_rd_en), .rec_addr(rec_addr),
        .rec_wr_data(rec_wr_data), .rec_rd_data(rec_rd_data),
        .eng_rst(eng_rst), .eng_en(eng_en), .eng_enc_start(eng_enc_start),
        .eng_dec_start(eng_dec_start), .eng_plaintext(eng_plaintext),
        .eng_ciphertext(eng_ciphertext), .eng_message(eng_message), .eng_tag(eng_tag),
        .eng_store_ready(eng_store_ready), .eng_auth_done(eng_auth_done),
        .eng_dec_fail(eng_dec_fail), .dbg_state(dbg_state)
    );

    // ---------------- toy cipher (fixed key/nonce) ----------------
    function automatic logic [31:0] ref_key();
        logic [63:0] iv;
        iv = ASCON_IV;
        return iv[63:32] ^ 32'h5a5a_c3c3;
    endfunction

    function automatic logic [31:0] ref_ct(input logic [31:0] pt);
        return {pt[15:0], pt[31:16]} ^ ref_key();
    endfunction

    function automatic logic [31:0] ref_pt(input logic [31:0] ct);
        logic [31:0] x;
        x = ct ^ ref_key();
        return {x[15:0], x[31:16]};
    endfunction

    function automatic logic [127:0] ref_tag(input logic [31:0] ct);
        return {ct ^ 32'h0123_4567, ~ct, ct + 32'h9e37_79b9, ct ^ 32'h0f0f_00ff};
    endfunction

    // ---------------- engine stub ----------------
    bit          hang_enc  = 1'b0;
    bit          hang_dec  = 1'b0;
    int          lat_force = -1;
    logic        enc_busy  = 1'b0;
    logic        dec_busy  = 1'b0;
    int          e_cnt     = 0;
    logic [31:0] e_pt      = '0;

    function automatic int pick_lat();
        return (lat_force >= 0) ? lat_force : int'($urandom_range(0, 20));
    endfunction

    always @(posedge clk) begin
        if (eng_rst) begin
            enc_busy        <= 1'b0;
            dec_busy        <= 1'b0;
            e_cnt           <= 0;
            eng_store_ready <= 1'b0;
            eng_auth_done   <= 1'b0;
            eng_dec_fail    <= 1'b0;
            eng_message     <= '0;
            eng_tag         <= '0;
        end else begin
            eng_store_ready <= 1'b0;
            if (eng_auth_done && !eng_en) eng_auth_done <= 1'b0;
            if (eng_enc_start) begin
                enc_busy <= 1'b1;
                e_pt     <= eng_plaintext;
                e_cnt    <= pick_lat();
            end else if (enc_busy && !hang_enc) begin
                if (e_cnt == 0) begin
                    enc_busy        <= 1'b0;
                    eng_store_ready <= 1'b1;
                    eng_message     <= ref_ct(e_pt);
                    eng_tag         <= ref_tag(ref_ct(e_pt));
                end else begin
                    e_cnt <= e_cnt - 1;
                end
            end
            if (eng_dec_start) begin
                dec_busy     <= 1'b1;
                eng_message  <= ref_pt(eng_ciphertext[159:128]);
                eng_dec_fail <= 1'b0;
                e_cnt        <= pick_lat();
            end else if (dec_busy && !hang_dec) begin
                if (e_cnt == 0) begin
                    dec_busy      <= 1'b0;
                    eng_auth_done <= 1'b1;
                    eng_message   <= '0;
                    eng_dec_fail  <= (ref_tag(eng_ciphertext[159:128]) !=
                                      {eng_ciphertext[63:0], eng_ciphertext[127:64]});
                end else begin
                    e_cnt <= e_cnt - 1;
                end
            end
        end
    end

    // ---------------- record memory ----------------
    logic [159:0]      mem [0:DEPTH-1] = '{default: '0};
    logic              corrupt_req  = 1'b0;
    logic [ADDR_W-1:0] corrupt_addr = '0;
    int                corrupt_bit  = 0;

    always @(posedge clk) begin
        if (rec_wr_en) mem[rec_addr] <= rec_wr_data;
        if (corrupt_req) mem[corrupt_addr][corrupt_bit] <= ~mem[corrupt_addr][corrupt_bit];
        if (rec_rd_en) rec_rd_data <= mem[rec_addr];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0]          mdl_pt    [0:DEPTH-1];
    bit                   mdl_valid [0:DEPTH-1];
    bit                   mdl_bad   [0:DEPTH-1];
    logic [33:0]          exp_q[$];
    logic [ADDR_W+159:0]  exp_rec_q[$];
    int                   n_tests = 0;
    int                   n_fail  = 0;
    bit                   hold_rsp = 1'b0;
    int                   enc_wait_run  = 0;
    int                   last_enc_wait = 0;
    seq_state_t           last_enc_exit = IDLE;
    seq_state_t           prev_state    = IDLE;
    int                   eng_rst_cycles = 0;

    task automatic check(input string name, input logic [169:0] act, input logic [169:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Response / record-write monitor
    initial begin
        logic [33:0]         e;
        logic [ADDR_W+159:0] er;
        forever begin
            @(negedge clk);
            if (rst) begin
                enc_wait_run = 0;
                prev_state   = IDLE;
            end else begin
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL rsp_unexpected: got status=%0d rdata=%h, required no response",
                                 bus.rsp_status, bus.rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_status_rdata", {bus.rsp_status, bus.rsp_rdata}, e);
                    end
                end
                if (rec_wr_en) begin
                    if (exp_rec_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL rec_wr_unexpected: got addr=%h, required no record write", rec_addr);
                    end else begin
                        er = exp_rec_q.pop_front();
                        check("rec_write", {rec_addr, rec_wr_data}, er);
                    end
                end
                if (dbg_state == ENC_WAIT) begin
                    enc_wait_run++;
                end else if (prev_state == ENC_WAIT) begin
                    last_enc_wait = enc_wait_run;
                    last_enc_exit = dbg_state;
                    enc_wait_run  = 0;
                end
                if (eng_rst) eng_rst_cycles++;
                prev_state = dbg_state;
            end
        end
    end

    // Response back-pressure
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit track);
        bit           to;
        int           n;
        logic [31:0]  ct;
        logic [127:0] tg;
        // The engine's result becomes visible lat+2 cycles into the wait phase.
        to = (wr ? hang_enc : hang_dec) || (lat_force >= 0 && lat_force + 2 > TIMEOUT_CYCLES);
        if (track) begin
            if (to) begin
                exp_q.push_back({ST_TIMEOUT, 32'h0});
            end else if (wr) begin
                ct = ref_ct(d);
                tg = ref_tag(ct);
                exp_q.push_back({ST_OK, 32'h0});
                exp_rec_q.push_back({a, ct, tg[63:0], tg[127:64]});
                mdl_pt[a]    = d;
                mdl_valid[a] = 1'b1;
                mdl_bad[a]   = 1'b0;
            end else if (mdl_valid[a] && !mdl_bad[a]) begin
                exp_q.push_back({ST_OK, mdl_pt[a]});
            end else begin
                exp_q.push_back({ST_AUTH_FAIL, 32'h0});
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 2000);
        if (!bus.req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL req_accept_timeout: got req_ready=0, required 1 within 2000 cycles");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dbg_state != IDLE) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_tests++; n_fail++;
            $display("FAIL wait_done_timeout: got %0d pending responses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic corrupt(input logic [ADDR_W-1:0] a, input int b);
        @(posedge clk);
        #1;
        corrupt_req  = 1'b1;
        corrupt_addr = a;
        corrupt_bit  = b;
        @(posedge clk);
        #1;
        corrupt_req  = 1'b0;
        mdl_bad[a]   = 1'b1;
    endtask

    // ---------------- global bound ----------------
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within 50000 cycles");
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  n, snap;
        bit  seen;
        logic [ADDR_W-1:0] a;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_pt[i] = '0; mdl_valid[i] = 1'b0; mdl_bad[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", dbg_state, IDLE);
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_rec_wr_en", rec_wr_en, 1'b0);
        check("reset_rec_rd_en", rec_rd_en, 1'b0);
        check("reset_eng_en", eng_en, 1'b0);
        check("reset_eng_rst", eng_rst, 1'b0);

        // Store, load back, then tamper with the tag and reload
        issue(1'b1, 10'h005, 32'h1234_5678, 1'b1); wait_done();
        issue(1'b0, 10'h005, 32'h0, 1'b1);         wait_done();
        corrupt(10'h005, 70);
        issue(1'b0, 10'h005, 32'h0, 1'b1);         wait_done();

        // Encryption never completes: watchdog recovery
        snap = eng_rst_cycles;
        hang_enc = 1'b1;
        issue(1'b1, 10'h010, 32'hcafe_f00d, 1'b1); wait_done();
        hang_enc = 1'b0;
        check("timeout_enc_wait_cycles", last_enc_wait, TIMEOUT_CYCLES);
        check("timeout_exit_state", last_enc_exit, RECOVER);
        check("timeout_eng_rst_pulse", eng_rst_cycles - snap, 1);
        issue(1'b0, 10'h010, 32'h0, 1'b1); wait_done();

        // Completion on the last allowed cycle wins; one cycle later times out
        lat_force = TIMEOUT_CYCLES - 2;
        issue(1'b1, 10'h011, 32'h0bad_beef, 1'b1); wait_done();
        check("late_done_enc_wait_cycles", last_enc_wait, TIMEOUT_CYCLES);
        check("late_done_exit_state", last_enc_exit, WR_REC);
        lat_force = TIMEOUT_CYCLES - 1;
        issue(1'b1, 10'h012, 32'h7777_8888, 1'b1); wait_done();
        lat_force = -1;

        // Decryption never completes
        hang_dec = 1'b1;
        issue(1'b0, 10'h011, 32'h0, 1'b1); wait_done();
        hang_dec = 1'b0;

        // Held response stays stable and blocks new requests
        issue(1'b1, 10'h020, 32'ha1b2_c3d4, 1'b1); wait_done();
        hold_rsp = 1'b1;
        repeat (2) @(posedge clk);
        issue(1'b0, 10'h020, 32'h0, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", bus.rsp_valid, 1'b1);
            check("hold_rsp_rdata", bus.rsp_rdata, 32'ha1b2_c3d4);
            check("hold_rsp_status", bus.rsp_status, ST_OK);
            check("hold_req_ready", bus.req_ready, 1'b0);
        end
        hold_rsp = 1'b0;
        wait_done();

        // Reset in the middle of decryption drops the load
        hang_dec = 1'b1;
        issue(1'b0, 10'h020, 32'h0, 1'b0);
        n = 0;
        while (dbg_state != DEC_WAIT && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_reached_dec_wait", dbg_state, DEC_WAIT);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        hang_dec = 1'b0;
        @(negedge clk);
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_req_ready", bus.req_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid || rec_wr_en) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_response", seen, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            a = 10'h040 + 10'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) corrupt(a, int'($urandom_range(0, 159)));
            if ($urandom_range(0, 1) == 1) begin
                hang_enc = ($urandom_range(0, 9) == 0);
                issue(1'b1, a, $urandom, 1'b1);
            end else begin
                hang_dec = ($urandom_range(0, 9) == 0);
                issue(1'b0, a, 32'h0, 1'b1);
            end
            wait_done();
            hang_enc = 1'b0;
            hang_dec = 1'b0;
        end

        repeat (5) @(negedge clk);
        check("exp_rsp_drained", exp_q.size(), 0);
        check("exp_rec_drained", exp_rec_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
